ifu_fetch_unit: RTL and testbench

// - Instruction fetch stage directly upstream of the L1 I-cache; also buffers what the cache returns.
// - Generates sequential PCs and issues one request at a time on the I-cache req handshake.
// - Collects cache responses into a small queue that presents {pc, instr} pairs to decode.
// - Handles redirects from branch/exception logic: flushes the queue and discards any stale in-flight response.

---
 rtl/ifu_fetch_unit_pkg.sv | 15 +
 rtl/ifu_fetch_fifo.sv | 56 +++++
 rtl/ifu_fetch_unit.sv | 117 +++++++++++
 tb/tb_ifu_fetch_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_unit_pkg.sv
// Shared fetch-stage types: FSM state encoding, instruction width, canonical NOP.
// No logic; imported by the fetch unit, its queue and the bench.
// Backpressure: n/a.
package ifu_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } ifu_state_t;

    localparam int INSTR_LEN = 32;
    localparam logic [INSTR_LEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Synchronous FIFO for {pc, instr} pairs with single-cycle flush.
// Latency: push visible at dout one cycle later; dout is combinational from the read pointer.
// Backpressure: push dropped when full unless a pop frees the slot in the same cycle.
module ifu_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_DEPTH);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ifu_fetch_unit.sv
// Fetch stage: sequential PC generation, one outstanding I-cache request, response queue to decode.
// Latency: response pushed on its handshake edge; visible to decode one cycle later.
// Backpressure: requests withheld while the queue has no free slot; cache responses always accepted.
module ifu_fetch_unit
    import ifu_fetch_unit_pkg::*;
#(
    parameter int                  ADDR_LEN = 32,
    parameter int                  DEPTH    = 4,
    parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid_i,
    input  logic [ADDR_LEN-1:0]  redirect_pc_i,
    output logic                 icache_req_valid_o,
    input  logic                 icache_req_ready_i,
    output logic [ADDR_LEN-1:0]  icache_req_addr_o,
    input  logic                 icache_resp_valid_i,
    output logic                 icache_resp_ready_o,
    input  logic [INSTR_LEN-1:0] icache_resp_data_i,
    output logic                 fetch_valid_o,
    input  logic                 fetch_ready_i,
    output logic [ADDR_LEN-1:0]  fetch_pc_o,
    output logic [INSTR_LEN-1:0] fetch_instr_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam int QW = ADDR_LEN + INSTR_LEN;

    ifu_state_t          state_q, state_d;
    logic [ADDR_LEN-1:0] pc_q, pc_d;
    logic [ADDR_LEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [ADDR_LEN-1:0] redirect_pc;
    logic                req_hsk;
    logic                resp_hsk;
    logic                push_en;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [QW-1:0]       fifo_dout;

    assign redirect_pc = {redirect_pc_i[ADDR_LEN-1:2], 2'b00};

    // A request is only issued when a queue slot is guaranteed for its response.
    assign icache_req_valid_o  = ~rst & (state_q == S_REQ) & (fifo_count < CNT_DEPTH);
    assign icache_req_addr_o   = pc_q;
    assign icache_resp_ready_o = ~rst;

    assign req_hsk  = icache_req_valid_o & icache_req_ready_i;
    assign resp_hsk = icache_resp_valid_i & icache_resp_ready_o;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        push_en       = 1'b0;
        unique case (state_q)
            S_REQ: begin
                if (req_hsk) begin
                    inflight_pc_d = pc_q;
                    state_d       = redirect_valid_i ? S_DROP : S_WAIT;
                end
                if (redirect_valid_i) pc_d = redirect_pc;
            end
            S_WAIT: begin
                if (resp_hsk && !redirect_valid_i) begin
                    push_en = 1'b1;
                    pc_d    = inflight_pc_q + ADDR_LEN'(4);
                    state_d = S_REQ;
                end else if (redirect_valid_i) begin
                    pc_d    = redirect_pc;
                    state_d = resp_hsk ? S_REQ : S_DROP;
                end
            end
            S_DROP: begin
                if (redirect_valid_i) pc_d = redirect_pc;
                if (resp_hsk) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Guard on full is redundant with the credit check but keeps the queue safe on its own.
    ifu_fetch_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid_i),
        .push  (push_en & ~fifo_full),
        .din   ({inflight_pc_q, icache_resp_data_i}),
        .pop   (fetch_ready_i),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fetch_valid_o = ~fifo_empty;
    assign fetch_pc_o    = fifo_dout[QW-1:INSTR_LEN];
    assign fetch_instr_o = fifo_dout[INSTR_LEN-1:0];

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Randomized bench for ifu_fetch_unit: the bench plays I-cache and decode and
// predicts the request stream and decoded {pc, instr} sequence from a transaction-level model.
module tb_ifu_fetch_unit;
    import ifu_fetch_unit_pkg::*;

    localparam int          AL       = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          clk;
    logic          rst;
    logic          redirect_valid_i;
    logic [AL-1:0] redirect_pc_i;
    logic          icache_req_valid_o;
    logic          icache_req_ready_i;
    logic [AL-1:0] icache_req_addr_o;
    logic          icache_resp_valid_i;
    logic          icache_resp_ready_o;
    logic [31:0]   icache_resp_data_i;
    logic          fetch_valid_o;
    logic          fetch_ready_i;
    logic [AL-1:0] fetch_pc_o;
    logic [31:0]   fetch_instr_o;

    ifu_fetch_unit #(
        .ADDR_LEN (AL),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .redirect_valid_i    (redirect_valid_i),
        .redirect_pc_i       (redirect_pc_i),
        .icache_req_valid_o  (icache_req_valid_o),
        .icache_req_ready_i  (icache_req_ready_i),
        .icache_req_addr_o   (icache_req_addr_o),
        .icache_resp_valid_i (icache_resp_valid_i),
        .icache_resp_ready_o (icache_resp_ready_o),
        .icache_resp_data_i  (icache_resp_data_i),
        .fetch_valid_o       (fetch_valid_o),
        .fetch_ready_i       (fetch_ready_i),
        .fetch_pc_o          (fetch_pc_o),
        .fetch_instr_o       (fetch_instr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fpair_t;

    // Transaction model: expected decode stream, next fetch address, outstanding request.
    fpair_t      mq[$];
    logic [31:0] m_addr;
    logic [31:0] m_inflight;
    bit          m_out;
    bit          m_stale;
    int          c_delay;
    logic [31:0] c_data;

    int vectors;
    int miscompares;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_addr     = RESET_PC;
        m_inflight = RESET_PC;
        m_out      = 1'b0;
        m_stale    = 1'b0;
        c_delay    = 0;
        c_data     = NOP_INSTR;
    endtask

    // One clock: drive inputs after the falling edge, check outputs, advance the model.
    task automatic cycle(input bit do_rst, input int p_rr, input int p_fr, input int p_rd_pm,
                         input int maxlat, input bit force_rd, input logic [31:0] force_pc);
        bit          exp_rv;
        bit          req_hsk;
        bit          resp_hsk;
        bit          pop;
        bit          rd;
        logic [31:0] rpc;
        fpair_t      ent;
        @(negedge clk);
        rst                = do_rst;
        icache_req_ready_i = ($urandom_range(99) < p_rr);
        fetch_ready_i      = ($urandom_range(99) < p_fr);
        rd                 = !do_rst && (force_rd || ($urandom_range(999) < p_rd_pm));
        redirect_valid_i   = rd;
        if (force_rd)
            redirect_pc_i = force_pc;
        else if ($urandom_range(3) == 0)
            redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        else
            redirect_pc_i = $urandom;
        icache_resp_valid_i = m_out && (c_delay == 0);
        icache_resp_data_i  = icache_resp_valid_i ? c_data : NOP_INSTR;
        #1;
        exp_rv = !do_rst && !m_out && (mq.size() < DEPTH);
        check_val("req_valid", 64'(icache_req_valid_o), 64'(exp_rv));
        if (exp_rv) check_val("req_addr", 64'(icache_req_addr_o), 64'(m_addr));
        check_val("resp_ready", 64'(icache_resp_ready_o), 64'(!do_rst));
        check_val("fetch_valid", 64'(fetch_valid_o), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check_val("fetch_pc", 64'(fetch_pc_o), 64'(mq[0].pc));
            check_val("fetch_instr", 64'(fetch_instr_o), 64'(mq[0].instr));
        end
        if (do_rst) begin
            model_reset();
        end else begin
            req_hsk  = exp_rv && icache_req_ready_i;
            resp_hsk = icache_resp_valid_i;
            pop      = (mq.size() != 0) && fetch_ready_i;
            rpc      = redirect_pc_i & 32'hFFFF_FFFC;
            if (pop) void'(mq.pop_front());
            if (rd) mq.delete();
            if (resp_hsk) begin
                if (!m_stale && !rd) begin
                    ent.pc    = m_inflight;
                    ent.instr = c_data;
                    mq.push_back(ent);
                    m_addr = m_inflight + 32'd4;
                end
                m_out = 1'b0;
            end else if (m_out && c_delay > 0) begin
                c_delay--;
            end
            if (req_hsk) begin
                m_out      = 1'b1;
                m_stale    = rd;
                m_inflight = m_addr;
                c_delay    = $urandom_range(maxlat);
                c_data     = $urandom;
            end
            if (rd) begin
                m_addr = rpc;
                if (m_out) m_stale = 1'b1;
            end
        end
    endtask

    initial begin
        vectors             = 0;
        miscompares         = 0;
        rst                 = 1'b1;
        redirect_valid_i    = 1'b0;
        redirect_pc_i       = '0;
        icache_req_ready_i  = 1'b0;
        icache_resp_valid_i = 1'b0;
        icache_resp_data_i  = NOP_INSTR;
        fetch_ready_i       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        repeat (3) cycle(1'b1, 100, 100, 0, 0, 1'b0, 32'h0);
        // Streaming with 1-cycle hits and decode always ready.
        repeat (40) cycle(1'b0, 100, 100, 0, 0, 1'b0, 32'h0);
        // Decode stalls: queue fills, requests stop, then resume.
        repeat (30) cycle(1'b0, 100, 0, 0, 0, 1'b0, 32'h0);
        repeat (30) cycle(1'b0, 100, 100, 0, 0, 1'b0, 32'h0);
        // Directed redirects, including misaligned and back-to-back targets.
        repeat (3) cycle(1'b0, 100, 50, 0, 2, 1'b0, 32'h0);
        cycle(1'b0, 100, 100, 0, 2, 1'b1, 32'h0000_1000);
        repeat (5) cycle(1'b0, 100, 100, 0, 2, 1'b0, 32'h0);
        cycle(1'b0, 100, 100, 0, 0, 1'b1, 32'h0000_2002);
        cycle(1'b0, 100, 100, 0, 3, 1'b1, 32'h0000_2802);
        cycle(1'b0, 100, 100, 0, 3, 1'b1, 32'h0000_3000);
        repeat (8) cycle(1'b0, 100, 100, 0, 0, 1'b0, 32'h0);
        // Address wrap at the top of the space, then reset mid-flight.
        cycle(1'b0, 100, 100, 0, 0, 1'b1, 32'hFFFF_FFFC);
        repeat (6) cycle(1'b0, 100, 100, 0, 0, 1'b0, 32'h0);
        cycle(1'b0, 100, 100, 0, 3, 1'b1, 32'h0000_0400);
        cycle(1'b0, 100, 100, 0, 3, 1'b0, 32'h0);
        cycle(1'b1, 100, 100, 0, 3, 1'b0, 32'h0);
        repeat (6) cycle(1'b0, 100, 100, 0, 0, 1'b0, 32'h0);

        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(299) == 0), 70, 60, 40, 3, 1'b0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
